piece_fit_checker: RTL and testbench

//  Sequencer that decides whether a 4-cell tetromino fits at a candidate position on the board.

---
 rtl/piece_fit_checker.sv | 132 +++++++++++++
 tb/tb_piece_fit_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/piece_fit_checker.sv
`default_nettype none
// ============================================================================
// Module      : piece_fit_checker
// Description : Walks the four cells of a tetromino through the collision unit
//               and reports a single fits / does-not-fit verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_fit_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] origin_x,
  input  logic [5:0] origin_y,
  input  logic [7:0] off_x,
  input  logic [7:0] off_y,
  output logic [4:0] chk_x,
  output logic [5:0] chk_y,
  input  logic       hit,
  output logic       ram_sel,
  output logic       busy,
  output logic       done,
  output logic       fits
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_addr = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [6:0] c_board_w = 7'(BOARD_W);
  localparam logic [6:0] c_board_h = 7'(BOARD_H);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       fits_q, fits_d;
  logic [5:0] org_x_q, org_y_q;
  logic [7:0] off_x_q, off_y_q;
  logic [4:0] chk_x_q;
  logic [5:0] chk_y_q;

  logic [6:0] w_ax, w_ay;
  logic       w_off_board;
  logic       w_accept;

  // Origin X is two's complement; a negative sum shows up as bit 6 set.
  assign w_ax = {org_x_q[5], org_x_q} + {5'b0, off_x_q[{idx_q, 1'b0} +: 2]};
  assign w_ay = {1'b0, org_y_q}       + {5'b0, off_y_q[{idx_q, 1'b0} +: 2]};

  assign w_off_board = w_ax[6] || (w_ax >= c_board_w) || (w_ay >= c_board_h);
  assign w_accept    = (state_q == c_st_idle) && start;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= c_st_idle;
      idx_q   <= 2'd0;
      fits_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fits_q  <= fits_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      org_x_q <= 6'd0;
      org_y_q <= 6'd0;
      off_x_q <= 8'd0;
      off_y_q <= 8'd0;
      chk_x_q <= 5'd0;
      chk_y_q <= 6'd0;
    end else begin
      if (w_accept) begin
        org_x_q <= origin_x;
        org_y_q <= origin_y;
        off_x_q <= off_x;
        off_y_q <= off_y;
      end
      if (state_q == c_st_addr) begin
        chk_x_q <= w_ax[4:0];
        chk_y_q <= w_ay[5:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fits_d  = fits_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d = c_st_addr;
          idx_d   = 2'd0;
          fits_d  = 1'b0;
        end
      end
      c_st_addr: begin
        // Off-board cells fail without consulting the RAM result.
        state_d = w_off_board ? c_st_done : c_st_wait;
      end
      c_st_wait: begin
        if (hit) begin
          state_d = c_st_done;
        end else if (idx_q == 2'd3) begin
          state_d = c_st_done;
          fits_d  = 1'b1;
        end else begin
          state_d = c_st_addr;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_comb begin
    ram_sel = (state_q == c_st_addr) || (state_q == c_st_wait);
    busy    = (state_q != c_st_idle);
    done    = (state_q == c_st_done);
    fits    = fits_q;
    chk_x   = (state_q == c_st_addr) ? w_ax[4:0] : chk_x_q;
    chk_y   = (state_q == c_st_addr) ? w_ay[5:0] : chk_y_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_piece_fit_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_piece_fit_checker
// Description : Directed and randomized checks of piece_fit_checker against a
//               cell-by-cell reference verdict and a registered board model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piece_fit_checker;

  localparam int W = 10;
  localparam int H = 24;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [5:0] origin_x = 6'd0;
  logic [5:0] origin_y = 6'd0;
  logic [7:0] off_x = 8'd0;
  logic [7:0] off_y = 8'd0;
  logic [4:0] chk_x;
  logic [5:0] chk_y;
  logic       hit = 1'b0;
  logic       ram_sel, busy, done, fits;

  logic board [H][W];
  int   checks = 0;
  int   failures = 0;

  piece_fit_checker #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .origin_x(origin_x), .origin_y(origin_y), .off_x(off_x), .off_y(off_y),
    .chk_x(chk_x), .chk_y(chk_y), .hit(hit),
    .ram_sel(ram_sel), .busy(busy), .done(done), .fits(fits)
  );

  always #5 clk = ~clk;

  // Board RAM: Q is registered one cycle after the read address.
  always @(posedge clk)
    hit <= (ram_sel && int'(chk_x) < W && int'(chk_y) < H) ? board[chk_y][chk_x] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        board[y][x] = 1'b0;
  endtask

  task automatic random_board(input int density);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        board[y][x] = ($urandom_range(0, 99) < density);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // first idle cycle after done.
  task automatic run_check(input logic [5:0] ox, input logic [5:0] oy,
                           input logic [7:0] fx, input logic [7:0] fy, input bit noisy);
    int ax[4];
    int ay[4];
    int sx, exp_c, ci;
    bit exp_fit;
    sx = (ox >= 6'd32) ? int'(ox) - 64 : int'(ox);
    for (int i = 0; i < 4; i++) begin
      ax[i] = sx + int'(fx[2*i +: 2]);
      ay[i] = int'(oy) + int'(fy[2*i +: 2]);
    end
    exp_fit = 1'b1;
    exp_c = 9;
    for (int i = 0; i < 4; i++) begin
      if (ax[i] < 0 || ax[i] >= W || ay[i] >= H) begin
        exp_c = 2*i + 2; exp_fit = 1'b0; break;
      end
      if (board[ay[i]][ax[i]]) begin
        exp_c = 2*i + 3; exp_fit = 1'b0; break;
      end
    end
    origin_x = ox; origin_y = oy; off_x = fx; off_y = fy;
    start = 1'b1;
    for (int c = 1; c <= exp_c + 1; c++) begin
      @(negedge clk);
      ci = (c - 1) / 2;
      check("busy", 32'(busy), 32'(c <= exp_c));
      check("ram_sel", 32'(ram_sel), 32'(c < exp_c));
      check("done", 32'(done), 32'(c == exp_c));
      check("fits", 32'(fits), 32'((c >= exp_c) ? exp_fit : 1'b0));
      if (c < exp_c) begin
        check("chk_x", 32'(chk_x), 32'(ax[ci] & 31));
        check("chk_y", 32'(chk_y), 32'(ay[ci] & 63));
      end
      if (noisy && c <= exp_c) begin
        start = 1'($urandom_range(0, 1));
        origin_x = 6'($urandom); origin_y = 6'($urandom);
        off_x = 8'($urandom); off_y = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    clear_board();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_sel", 32'(ram_sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fits", 32'(fits), 32'd0);
    check("rst_chk", 32'({chk_x, chk_y}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Square piece on an empty board, then with (5,0) occupied.
    run_check(6'd3, 6'd0, 8'h99, 8'h50, 1'b0);
    board[0][5] = 1'b1;
    run_check(6'd3, 6'd0, 8'h99, 8'h50, 1'b0);
    clear_board();

    // Left edge, bottom edge and right edge boundaries.
    run_check(6'b111111, 6'd0, 8'h00, 8'h00, 1'b0);
    run_check(6'd8, 6'd22, 8'h55, 8'h20, 1'b0);
    run_check(6'd8, 6'd0, 8'h55, 8'h00, 1'b0);
    run_check(6'd8, 6'd0, 8'h02, 8'h00, 1'b0);

    // Start held high: one accepted check per return to idle.
    origin_x = 6'd3; origin_y = 6'd0; off_x = 8'h99; off_y = 8'h50;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check("held_done", 32'(done), 32'(c % 10 == 9));
      check("held_busy", 32'(busy), 32'(c % 10 != 0));
    end
    start = 1'b0;
    @(negedge clk);

    // Reset during cycle 4 of a check.
    origin_x = 6'd3; origin_y = 6'd0; off_x = 8'h99; off_y = 8'h50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ram_sel", 32'(ram_sel), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fits", 32'(fits), 32'd0);
    check("abort_chk", 32'({chk_x, chk_y}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_check(6'd3, 6'd0, 8'h99, 8'h50, 1'b0);

    // Randomized pieces, boards and noisy inputs while busy.
    for (int n = 0; n < 40; n++) begin
      random_board((n % 3 == 0) ? 0 : 12);
      run_check(6'($urandom), 6'($urandom_range(0, 25)), 8'($urandom), 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
